// File: rtl/shiftreg_y_ctrl.sv
// ---------------------------------------------------------------------------
// shiftreg_y_ctrl
//
// Sequencer for the 2048-bit Y shift register (NW words of W bits) used by
// the modular-exponentiation datapath. Each single-cycle command becomes a
// correctly counted drive sequence on the register's load/enable/mode pins:
//   LOAD  (00) : one-cycle parallel load pulse
//   WRITE (01) : NW-word serial fill from a valid/ready write stream
//   READ  (10) : NW-word serial drain to a valid/ready read stream
//   SCAN  (11) : LSB-first bit scan of min(count, W*NW) bits
//
// Optional feature macro: SHIFTREG_Y_CTRL_ROTATE_EN
//   defined   -> READ feeds the drained word back in at the top, so the
//                register holds its original value after a full read.
//   undefined -> READ shifts in zeros; the register is 0 after a full read.
//
// Ports:
//   iClk, iReset        clock, asynchronous active-high reset
//   iStart, iCmd        command strobe (sampled only in IDLE) and opcode
//   iBitCount           number of bits for SCAN
//   oLoad/oEnable/oMode shift-register control (mode 00 shr32, 01 shr1, 11 hold)
//   oDataShiftReg       word inserted at the top on shr32
//   iDataShiftReg       shift-register bits [W-1:0]
//   iWrData/iWrValid/oWrReady   write stream
//   oRdData/oRdValid/iRdReady   read stream
//   oBit/oBitValid/iBitReady    scanned-bit stream
//   oBusy               high in every state except IDLE
//   oDone               one-cycle completion pulse
//
// Stream outputs are combinational decodes of the state so a transfer and
// its shift happen in the same cycle as the handshake.
// ---------------------------------------------------------------------------
module shiftreg_y_ctrl #(
  parameter int W  = 32,
  parameter int NW = 64,
  parameter int CW = 12
) (
  input  logic          iClk,
  input  logic          iReset,
  input  logic          iStart,
  input  logic [1:0]    iCmd,
  input  logic [CW-1:0] iBitCount,
  output logic          oLoad,
  output logic          oEnable,
  output logic [1:0]    oMode,
  output logic [W-1:0]  oDataShiftReg,
  input  logic [W-1:0]  iDataShiftReg,
  input  logic [W-1:0]  iWrData,
  input  logic          iWrValid,
  output logic          oWrReady,
  output logic [W-1:0]  oRdData,
  output logic          oRdValid,
  input  logic          iRdReady,
  output logic          oBit,
  output logic          oBitValid,
  input  logic          iBitReady,
  output logic          oBusy,
  output logic          oDone
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_WR   = 3'd2,
    S_RD   = 3'd3,
    S_SCAN = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [1:0] CMD_LOAD   = 2'b00;
  localparam logic [1:0] CMD_WRITE  = 2'b01;
  localparam logic [1:0] CMD_READ   = 2'b10;
  localparam logic [1:0] CMD_SCAN   = 2'b11;

  localparam logic [1:0] MODE_SHR32 = 2'b00;
  localparam logic [1:0] MODE_SHR1  = 2'b01;
  localparam logic [1:0] MODE_HOLD  = 2'b11;

  localparam int          BITS      = W * NW;
  localparam logic [6:0]  WORD_LAST = 7'(NW - 1);
  // One bit wider than the count so the W*NW ceiling is always representable.
  localparam logic [CW:0] MAX_BITS  = (CW + 1)'(BITS);
  localparam logic [CW:0] ONE_EXT   = (CW + 1)'(1);

  state_t        state_q, state_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [CW-1:0] count_q, count_d;
  logic [6:0]    word_cnt_q, word_cnt_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;

  logic [CW:0]   n_eff_s;
  logic          bit_last_s;

  // Shift mode used for a transfer of the latched command.
  function automatic logic [1:0] xfer_mode(input logic [1:0] cmd);
    logic [1:0] m;
    case (cmd)
      CMD_SCAN: m = MODE_SHR1;
      default:  m = MODE_SHR32;
    endcase
    return m;
  endfunction

  // Effective scan length, clamped to the register size.
  assign n_eff_s    = ({1'b0, count_q} > MAX_BITS) ? MAX_BITS : {1'b0, count_q};
  // The transfer in flight is the last one of the scan.
  assign bit_last_s = (({1'b0, bit_cnt_q} + ONE_EXT) == n_eff_s);

  // Next-state, counter and output decode.
  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    count_d       = count_q;
    word_cnt_d    = word_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    oLoad         = 1'b0;
    oEnable       = 1'b0;
    oMode         = MODE_HOLD;
    oDataShiftReg = {W{1'b0}};
    oWrReady      = 1'b0;
    oRdData       = {W{1'b0}};
    oRdValid      = 1'b0;
    oBit          = 1'b0;
    oBitValid     = 1'b0;
    oDone         = 1'b0;
    oBusy         = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          cmd_d      = iCmd;
          count_d    = iBitCount;
          word_cnt_d = 7'd0;
          bit_cnt_d  = {CW{1'b0}};
          case (iCmd)
            CMD_LOAD:  state_d = S_LOAD;
            CMD_WRITE: state_d = S_WR;
            CMD_READ:  state_d = S_RD;
            CMD_SCAN:  state_d = S_SCAN;
            default:   state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOAD: begin
        oLoad   = 1'b1;
        state_d = S_DONE;
      end

      S_WR: begin
        oWrReady = 1'b1;
        if (iWrValid) begin
          oEnable       = 1'b1;
          oMode         = xfer_mode(cmd_q);
          oDataShiftReg = iWrData;
          word_cnt_d    = word_cnt_q + 7'd1;
          if (word_cnt_q == WORD_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WR;
          end
        end else begin
          state_d = S_WR;
        end
      end

      S_RD: begin
        oRdValid = 1'b1;
        oRdData  = iDataShiftReg;
        if (iRdReady) begin
          oEnable = 1'b1;
          oMode   = xfer_mode(cmd_q);
`ifdef SHIFTREG_Y_CTRL_ROTATE_EN
          oDataShiftReg = iDataShiftReg;
`else
          oDataShiftReg = {W{1'b0}};
`endif
          word_cnt_d = word_cnt_q + 7'd1;
          if (word_cnt_q == WORD_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RD;
          end
        end else begin
          state_d = S_RD;
        end
      end

      S_SCAN: begin
        // A zero-length scan passes straight through without offering a bit.
        if (n_eff_s == {(CW + 1){1'b0}}) begin
          state_d = S_DONE;
        end else begin
          oBitValid = 1'b1;
          oBit      = iDataShiftReg[0];
          if (iBitReady) begin
            oEnable   = 1'b1;
            oMode     = xfer_mode(cmd_q);
            bit_cnt_d = bit_cnt_q + {{(CW - 1){1'b0}}, 1'b1};
            if (bit_last_s) begin
              state_d = S_DONE;
            end else begin
              state_d = S_SCAN;
            end
          end else begin
            state_d = S_SCAN;
          end
        end
      end

      S_DONE: begin
        oDone   = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, latched command and counters.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q    <= S_IDLE;
      cmd_q      <= 2'b00;
      count_q    <= {CW{1'b0}};
      word_cnt_q <= 7'd0;
      bit_cnt_q  <= {CW{1'b0}};
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      count_q    <= count_d;
      word_cnt_q <= word_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

endmodule
